muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one step per clock.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiplies through one
// hardware multiplier; divides are unaffected). Without it no multiplier is inferred.
//
// Handshake: start is sampled only in IDLE. kill in IDLE drops a coincident start.
// busy is high from the start edge through the DONE cycle. done is a one-cycle
// pulse in the DONE cycle. result holds until the next operation that reaches DONE.
// busy, done and dbg_state are decodes of the state register, so no input reaches
// an output combinationally. The result is written on the edge that enters DONE,
// so kill in the DONE cycle cannot retract a result that is already visible.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [2:0]           op_q;
    logic                 sa_q, sb_q;
    logic [WIDTH-1:0]     b_mag_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     result_q;

    // Decode of the incoming request
    logic                 is_div_in, a_signed_in, b_signed_in, sa_in, sb_in;
    logic [WIDTH-1:0]     a_mag_in, b_mag_in;
    logic                 div_zero, div_ovf, fast_path, go_done;
    logic [WIDTH-1:0]     special_res, fast_res, start_res;

    // Iteration step and final fix-up
    logic [WIDTH:0]       mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, step_next, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix, calc_res;

    // Request decode: signedness, magnitudes, special cases, and start-time result
    always_comb begin
        is_div_in   = funct3[2];
        a_signed_in = is_div_in ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        b_signed_in = is_div_in ? ~funct3[0] : (funct3[1:0] == 2'b01);
        sa_in       = a_signed_in & a[WIDTH-1];
        sb_in       = b_signed_in & b[WIDTH-1];
        a_mag_in    = sa_in ? -a : a;
        b_mag_in    = sb_in ? -b : b;
        div_zero    = is_div_in && (b == '0);
        div_ovf     = is_div_in && !funct3[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        // Remainder ops: a on divide-by-zero, 0 on overflow; quotient ops: all ones / MIN
        if (div_zero)
            special_res = funct3[1] ? a : '1;
        else
            special_res = funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
        begin : fast_mul
            logic [2*WIDTH-1:0] fa, fb, fp;
            fa = {{WIDTH{sa_in}}, a};
            fb = {{WIDTH{sb_in}}, b};
            fp = fa * fb;
            fast_res  = (funct3[1:0] == 2'b00) ? fp[WIDTH-1:0] : fp[2*WIDTH-1:WIDTH];
            fast_path = !is_div_in;
        end
`else
        fast_res  = '0;
        fast_path = 1'b0;
`endif
        go_done   = div_zero || div_ovf || fast_path;
        start_res = (div_zero || div_ovf) ? special_res : fast_res;
    end

    // One radix-2 step on the shared accumulator, plus sign fix-up and result select
    always_comb begin
        // Multiply: high half accumulates b, low half holds the shifting multiplier
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        // Divide: high half is the partial remainder, low half dividend/quotient
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_mag_q};
        if (!rem_diff[WIDTH])
            div_next = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        step_next = op_q[2] ? div_next : mul_next;
        prod_fix  = (sa_q ^ sb_q) ? -step_next : step_next;
        quo_fix   = (sa_q ^ sb_q) ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
        rem_fix   = sa_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000:                 calc_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         calc_res = quo_fix;
            default:                calc_res = rem_fix;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && !kill) state_d = go_done ? S_DONE : S_CALC;
            S_CALC: begin
                if (kill)
                    state_d = S_IDLE;
                else if (cnt_q == CW'(1))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Datapath registers: capture at start, iterate in CALC, write result entering DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !kill) begin
                        op_q    <= funct3;
                        sa_q    <= sa_in;
                        sb_q    <= sb_in;
                        b_mag_q <= b_mag_in;
                        acc_q   <= {{WIDTH{1'b0}}, a_mag_in};
                        cnt_q   <= CW'(WIDTH);
                        if (go_done) result_q <= start_res;
                    end
                end
                S_CALC: begin
                    if (!kill) begin
                        acc_q <= step_next;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) result_q <= calc_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a
// 64-bit arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        kill = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
        .kill(kill), .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // reference model: RV32M semantics from 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'(x);
        longint uy = longint'(y);
        logic [63:0] p;
        case (f3)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN32 && y == 32'hFFFF_FFFF) return MIN32;
                p = sx / sy; return p[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == MIN32 && y == 32'hFFFF_FFFF) return 32'd0;
                p = sx % sy; return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // expected cycle (counted from the start edge) in which done appears
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        if (f3[2] && (y == 0 || (!f3[0] && x == MIN32 && y == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 33;
    endfunction

    // driver: called at posedge+1; start is sampled on the next edge.
    // Optionally injects a stray start pulse in cycle inj of the operation.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y, input int inj,
                          output logic [31:0] res, output int lat, output bit busy_bad, output bit tail_bad);
        start = 1'b1; funct3 = f3; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_bad = 1'b0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (lat == inj) begin
                start = 1'b1; funct3 = 3'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        res = result;
        if (busy !== 1'b1) busy_bad = 1'b1;
        @(posedge clk); #1;
        tail_bad = (busy !== 1'b0) || (done !== 1'b0) || (result !== res);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b result=%h state=%0d required 0 0 0 0", busy, done, result, dbg_state);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [10] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6};
        logic [31:0] as  [10] = '{32'd7, MIN32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd0, 32'h7FFF_FFFF};
        logic [31:0] bs  [10] = '{32'hFFFF_FFFD, MIN32, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7, 32'd5, 32'hFFFF_FFFE};
        logic [31:0] exs [10] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'd0, 32'd1};
        logic [31:0] res;
        int lat;
        bit bb, tb;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(exs[i]);
            run_op(f3s[i], as[i], bs[i], 0, res, lat, bb, tb);
            begin
                logic [31:0] e = exp_q.pop_front();
                checks++;
                if (res !== e) begin
                    errors++;
                    $display("FAIL directed_result[%0d] f3=%0d got %h required %h", i, f3s[i], res, e);
                end
            end
            checks++;
            if (lat !== ref_latency(f3s[i], as[i], bs[i]) || bb || tb) begin
                errors++;
                $display("FAIL directed_timing[%0d] done_cycle=%0d required %0d busy_gap=%0b tail_bad=%0b",
                         i, lat, ref_latency(f3s[i], as[i], bs[i]), bb, tb);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3s [6] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd7, 3'd4};
        logic [31:0] as  [6] = '{32'h1234, 32'h1234, MIN32, MIN32, 32'hDEAD_BEEF, 32'hFFFF_FF00};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exs [6] = '{32'hFFFF_FFFF, 32'h1234, MIN32, 32'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
        logic [31:0] res;
        int lat;
        bit bb, tb;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exs[i]);
            run_op(f3s[i], as[i], bs[i], 0, res, lat, bb, tb);
            begin
                logic [31:0] e = exp_q.pop_front();
                checks++;
                if (res !== e || lat !== 1 || bb || tb) begin
                    errors++;
                    $display("FAIL special[%0d] got %h at cycle %0d required %h at cycle 1 (busy_gap=%0b tail_bad=%0b)",
                             i, res, lat, e, bb, tb);
                end
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] pool [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, MIN32, 32'h7FFF_FFFF};
        logic [2:0]  f3;
        logic [31:0] x, y, res;
        int lat;
        bit bb, tb;
        for (int i = 0; i < n; i++) begin
            f3 = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(1, 31);
            exp_q.push_back(ref_model(f3, x, y));
            run_op(f3, x, y, 0, res, lat, bb, tb);
            begin
                logic [31:0] e = exp_q.pop_front();
                checks++;
                if (res !== e || lat !== ref_latency(f3, x, y) || bb || tb) begin
                    errors++;
                    $display("FAIL random[%0d] f3=%0d a=%h b=%h got %h cycle %0d required %h cycle %0d",
                             i, f3, x, y, res, lat, e, ref_latency(f3, x, y));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3;
        logic [31:0] x, y, res;
        int lat;
        bit bb, tb;
        // run_op returns in the idle cycle, so each new start lands on the earliest legal edge
        for (int i = 0; i < 6; i++) begin
            f3 = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom | 32'd1;
            exp_q.push_back(ref_model(f3, x, y));
            run_op(f3, x, y, 0, res, lat, bb, tb);
            begin
                logic [31:0] e = exp_q.pop_front();
                checks++;
                if (res !== e || lat !== ref_latency(f3, x, y) || bb || tb) begin
                    errors++;
                    $display("FAIL back_to_back[%0d] got %h cycle %0d required %h cycle %0d", i, res, lat, e, ref_latency(f3, x, y));
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] res;
        int lat;
        bit bb, tb;
        exp_q.push_back(32'd14);
        run_op(3'd5, 32'd100, 32'd7, 5, res, lat, bb, tb);
        begin
            logic [31:0] e = exp_q.pop_front();
            checks++;
            if (res !== e || lat !== 33 || bb || tb) begin
                errors++;
                $display("FAIL start_while_busy got %h cycle %0d required %h cycle 33", res, lat, e);
            end
        end
    endtask

    task automatic test_kill();
        logic [31:0] prior, res;
        int lat;
        bit bb, tb, saw_done;
        prior = result;
        // kill sampled on the 10th edge of a DIV
        start = 1'b1; funct3 = 3'd4; a = $urandom; b = $urandom | 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== prior) begin
            errors++;
            $display("FAIL kill_calc busy=%b done=%b result=%h required 0 0 %h", busy, done, result, prior);
        end
        // new start the following cycle completes normally
        exp_q.push_back(32'hFFFF_FFFD);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, res, lat, bb, tb);
        begin
            logic [31:0] e = exp_q.pop_front();
            checks++;
            if (res !== e || lat !== 33 || bb || tb) begin
                errors++;
                $display("FAIL kill_restart got %h cycle %0d required %h cycle 33", res, lat, e);
            end
        end
        // killed operation never produces done and leaves result alone
        prior = result;
        start = 1'b1; funct3 = 3'd5; a = $urandom; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1 || result !== prior) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL kill_suppress activity after kill result=%h required idle with %h", result, prior);
        end
        // kill in IDLE drops a coincident start
        start = 1'b1; kill = 1'b1; funct3 = 3'd0; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL kill_idle busy=%b state=%0d required 0 0", busy, dbg_state);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat;
        bit bb, tb;
        start = 1'b1; funct3 = 3'd1; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_async busy=%b done=%b result=%h required 0 0 0", busy, done, result);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(32'd15);
        run_op(3'd0, 32'd3, 32'd5, 0, res, lat, bb, tb);
        begin
            logic [31:0] e = exp_q.pop_front();
            checks++;
            if (res !== e || lat !== ref_latency(3'd0, 32'd3, 32'd5) || bb || tb) begin
                errors++;
                $display("FAIL reset_recover got %h cycle %0d required %h cycle %0d", res, lat, e, ref_latency(3'd0, 32'd3, 32'd5));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_random(40);
        test_back_to_back();
        test_start_ignored();
        test_kill();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
